// File: rtl/nv_cdc_toggle_tx_pkg.sv
// Shared constants for the source half of the toggle-handshake CDC.
// FSM encoding, default sizing and the handshake-completion test.
package nv_cdc_toggle_tx_pkg;

    localparam logic TX_IDLE = 1'b0;
    localparam logic TX_BUSY = 1'b1;

    localparam int NV_CDC_DEF_DW          = 32;
    localparam int NV_CDC_DEF_SYNC_STAGES = 3;

    // A transfer is complete once the synchronized ack level has caught up with req.
    function automatic logic ack_matches(input logic ack_s, input logic req);
        return ack_s == req;
    endfunction

endpackage

// File: rtl/nv_cdc_ack_sync.sv
// Clear-to-0 multi-flop synchronizer for the returning ack toggle.
// Pure flop chain: no logic between stages so each stage gets a full period to resolve.
module nv_cdc_ack_sync
    import nv_cdc_toggle_tx_pkg::*;
#(
    parameter int SYNC_STAGES = NV_CDC_DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/nv_cdc_toggle_tx.sv
// Source-side 2-phase toggle CDC launcher: captures a word, flips cdc_req, waits for the echoed ack.
// Optional sticky protocol checker (ack_err) enabled by defining NV_CDC_TOGGLE_TX_ACK_CHK_EN.
module nv_cdc_toggle_tx
    import nv_cdc_toggle_tx_pkg::*;
#(
    parameter int DW          = NV_CDC_DEF_DW,
    parameter int SYNC_STAGES = NV_CDC_DEF_SYNC_STAGES
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          src_valid,
    output logic          src_ready,
    input  logic [DW-1:0] src_data,
    output logic          cdc_req,
    output logic [DW-1:0] cdc_data,
    input  logic          cdc_ack,
    output logic          tx_busy
`ifdef NV_CDC_TOGGLE_TX_ACK_CHK_EN
    ,
    output logic          ack_err
`endif
);

    logic state;
    logic ack_s;

    nv_cdc_ack_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (nvdla_core_clk),
        .rst_n (nvdla_core_rstn),
        .d     (cdc_ack),
        .q     (ack_s)
    );

    // Data and req launch on the same edge and stay frozen until the ack returns.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state    <= TX_IDLE;
            cdc_req  <= 1'b0;
            cdc_data <= '0;
        end else if (state == TX_IDLE) begin
            if (src_valid) begin
                cdc_data <= src_data;
                cdc_req  <= ~cdc_req;
                state    <= TX_BUSY;
            end
        end else begin
            if (ack_matches(ack_s, cdc_req)) begin
                state <= TX_IDLE;
            end
        end
    end

    assign src_ready = (state == TX_IDLE);
    assign tx_busy   = (state == TX_BUSY);

`ifdef NV_CDC_TOGGLE_TX_ACK_CHK_EN
    logic ack_s_p1;
    logic ack_chg;

    assign ack_chg = (ack_s != ack_s_p1);

    // Any ack edge is illegal while idle; while busy it must land on the current req level.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            ack_s_p1 <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            ack_s_p1 <= ack_s;
            if (ack_chg && ((state == TX_IDLE) || !ack_matches(ack_s, cdc_req))) begin
                ack_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nv_cdc_toggle_tx.sv
// Directed bench for nv_cdc_toggle_tx (default DW=32, SYNC_STAGES=3).
// Covers ack_err as well when NV_CDC_TOGGLE_TX_ACK_CHK_EN is defined.
module tb_nv_cdc_toggle_tx;

    logic        clk;
    logic        rstn;
    logic        src_valid;
    logic        src_ready;
    logic [31:0] src_data;
    logic        cdc_req;
    logic [31:0] cdc_data;
    logic        cdc_ack;
    logic        tx_busy;
`ifdef NV_CDC_TOGGLE_TX_ACK_CHK_EN
    logic        ack_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] data;
        logic        exp_req;
    } vec_t;

    vec_t vecs[4];

    nv_cdc_toggle_tx #(
        .DW          (32),
        .SYNC_STAGES (3)
    ) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .src_data        (src_data),
        .cdc_req         (cdc_req),
        .cdc_data        (cdc_data),
        .cdc_ack         (cdc_ack),
        .tx_busy         (tx_busy)
`ifdef NV_CDC_TOGGLE_TX_ACK_CHK_EN
        ,
        .ack_err         (ack_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        cdc_ack   = 1'b0;
        src_valid = 1'b0;
        src_data  = '0;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic do_accept(input logic [31:0] d);
        src_data  = d;
        src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{data: 32'h0000_0001, exp_req: 1'b1};
        vecs[1] = '{data: 32'h0000_0002, exp_req: 1'b0};
        vecs[2] = '{data: 32'h0000_0003, exp_req: 1'b1};
        vecs[3] = '{data: 32'h0000_0004, exp_req: 1'b0};

        rstn      = 1'b0;
        cdc_ack   = 1'b0;
        src_valid = 1'b0;
        src_data  = '0;
        tick();
        tick();
        chk1 ("rst_req",   cdc_req,   1'b0);
        chk32("rst_data",  cdc_data,  32'h0);
        chk1 ("rst_ready", src_ready, 1'b1);
        chk1 ("rst_busy",  tx_busy,   1'b0);
`ifdef NV_CDC_TOGGLE_TX_ACK_CHK_EN
        chk1 ("rst_ack_err", ack_err, 1'b0);
`endif
        rstn = 1'b1;
        tick();

        // Single transfer; ack sampled at edge M, IDLE after edge M+3.
        do_accept(32'hDEAD_BEEF);
        chk1 ("single_req",   cdc_req,   1'b1);
        chk32("single_data",  cdc_data,  32'hDEAD_BEEF);
        chk1 ("single_ready", src_ready, 1'b0);
        chk1 ("single_busy",  tx_busy,   1'b1);
        cdc_ack = 1'b1;
        repeat (3) tick();
        chk1 ("single_ready_early", src_ready, 1'b0);
        tick();
        chk1 ("single_ready_done", src_ready, 1'b1);
        chk1 ("single_busy_done",  tx_busy,   1'b0);
        chk32("single_data_held",  cdc_data,  32'hDEAD_BEEF);
        chk1 ("single_req_held",   cdc_req,   1'b1);

        // Back-to-back with src_valid held high; ack echoes 5 cycles after each accept.
        do_reset();
        src_valid = 1'b1;
        src_data  = vecs[0].data;
        for (int i = 0; i < 4; i++) begin
            int cnt;
            cnt = 0;
            while (src_ready !== 1'b1 && cnt < 50) begin
                if (i > 0) chk32("b2b_hold", cdc_data, vecs[i-1].data);
                tick();
                cnt++;
            end
            if (cnt >= 50) chk1("b2b_ready_timeout", src_ready, 1'b1);
            src_data = vecs[i].data;
            tick();
            chk1 ("b2b_req",   cdc_req,   vecs[i].exp_req);
            chk32("b2b_data",  cdc_data,  vecs[i].data);
            chk1 ("b2b_ready", src_ready, 1'b0);
            repeat (5) tick();
            chk32("b2b_data_pre_ack", cdc_data, vecs[i].data);
            cdc_ack = vecs[i].exp_req;
        end
        src_valid = 1'b0;
        begin
            int cnt;
            cnt = 0;
            while (src_ready !== 1'b1 && cnt < 50) begin
                tick();
                cnt++;
            end
            if (cnt >= 50) chk1("b2b_final_timeout", src_ready, 1'b1);
        end
        repeat (5) tick();
        chk1 ("b2b_final_req",  cdc_req,  1'b0);
        chk32("b2b_final_data", cdc_data, 32'h0000_0004);
        chk1 ("b2b_final_busy", tx_busy,  1'b0);

        // Stall: ack withheld for 100 cycles.
        do_reset();
        do_accept(32'hA5A5_0001);
        for (int c = 0; c < 100; c++) begin
            chk1 ("stall_req",   cdc_req,   1'b1);
            chk32("stall_data",  cdc_data,  32'hA5A5_0001);
            chk1 ("stall_ready", src_ready, 1'b0);
            tick();
        end
        cdc_ack = 1'b1;
        repeat (4) tick();
        chk1 ("stall_release", src_ready, 1'b1);

        // Reset while BUSY: asynchronous clear, then a fresh accept toggles req to 1 again.
        do_reset();
        do_accept(32'h0BAD_F00D);
        tick();
        chk1("mid_busy_before", tx_busy, 1'b1);
        rstn    = 1'b0;
        cdc_ack = 1'b0;
        #1;
        chk1 ("mid_rst_req",   cdc_req,   1'b0);
        chk32("mid_rst_data",  cdc_data,  32'h0);
        chk1 ("mid_rst_ready", src_ready, 1'b1);
        chk1 ("mid_rst_busy",  tx_busy,   1'b0);
        tick();
        rstn = 1'b1;
        tick();
        do_accept(32'h1234_5678);
        chk1 ("post_rst_req",  cdc_req,  1'b1);
        chk32("post_rst_data", cdc_data, 32'h1234_5678);
        cdc_ack = 1'b1;
        repeat (3) tick();
        chk1("post_rst_ready_early", src_ready, 1'b0);
        tick();
        chk1("post_rst_ready", src_ready, 1'b1);

        // Spurious ack toggle while IDLE.
        do_reset();
        cdc_ack = 1'b1;
        repeat (3) tick();
`ifdef NV_CDC_TOGGLE_TX_ACK_CHK_EN
        chk1("ack_err_early", ack_err, 1'b0);
`endif
        tick();
`ifdef NV_CDC_TOGGLE_TX_ACK_CHK_EN
        chk1("ack_err_set", ack_err, 1'b1);
`endif
        repeat (5) tick();
        chk1("idle_ack_ready", src_ready, 1'b1);
        chk1("idle_ack_req",   cdc_req,   1'b0);
        chk1("idle_ack_busy",  tx_busy,   1'b0);
        // Next accept drives req to 1, which already equals the synchronized ack.
        do_accept(32'hCAFE_0001);
        chk1 ("idle_ack_acc_req",  cdc_req,  1'b1);
        chk1 ("idle_ack_acc_busy", tx_busy,  1'b1);
        tick();
        chk1 ("idle_ack_acc_done", src_ready, 1'b1);
        chk32("idle_ack_acc_data", cdc_data, 32'hCAFE_0001);
`ifdef NV_CDC_TOGGLE_TX_ACK_CHK_EN
        chk1("ack_err_sticky", ack_err, 1'b1);
        rstn = 1'b0;
        #1;
        chk1("ack_err_cleared", ack_err, 1'b0);
        tick();
        rstn = 1'b1;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
